fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch stage directly upstream of the CPU core.
- Issues sequential PC-addressed reads to instruction memory and buffers returned 16-bit instructions in a small FIFO.
- Presents instructions to the CPU's decode/execute stage over a valid/ready handshake.
- Handles PC redirects from the core: flushes the FIFO, discards stale in-flight responses, restarts fetch at the new PC.

Parameters:
- PC_WIDTH, 8, width of fetch PC and memory address.
- INSTRUCTION_WIDTH, 16, instruction word width; opcode is bits [15:12].
- DEPTH, 4, FIFO entries and also the max outstanding-plus-buffered credit; power of two, >=2.

Ports:
- clock  in  1  rising-edge clock.
- isResetN  in  1  asynchronous active-low reset.
- memReq  out  1  read request strobe, one per cycle max.
- memAddr  out  PC_WIDTH  request address, valid when memReq=1.
- memData  in  INSTRUCTION_WIDTH  returned instruction word.
- memValid  in  1  response strobe; responses return in request order, latency >=1 cycle, variable.
- instruction  out  INSTRUCTION_WIDTH  FIFO head word.
- instrPc  out  PC_WIDTH  PC of FIFO head.
- instrValid  out  1  head entry valid.
- instrReady  in  1  CPU accepts head this cycle.
- redirect  in  1  one-cycle pulse: restart fetch at redirectPc.
- redirectPc  in  PC_WIDTH  new fetch PC.
- halted  out  1  fetch stopped on HALT opcode (see Optional Feature; tied 0 when feature is compiled out).

Behaviour:
- Reset (async assert, sync deassert at the next edge): fetchPc=0, FIFO empty, outstanding=0, dropCount=0, memReq=0, memAddr=0, instrValid=0, instruction=0, instrPc=0, halted=0.
- Credit: credit = DEPTH - occupancy - outstanding.
- Issue: memReq=1 when credit>0, no redirect this cycle, and not halted. memAddr=fetchPc. fetchPc increments mod 2^PC_WIDTH on issue (0xFF wraps to 0x00 at default width).
- Each issue records its PC in an in-order tag queue of DEPTH entries.
- Response with dropCount=0: memValid pushes {memData, tagged PC} into the FIFO.
- Response with dropCount>0: the response is discarded and dropCount decrements.
- In either case outstanding decrements.
- FIFO cannot overflow by construction. A memValid with outstanding=0 is a protocol error: ignored, with a simulation $error.
- Output: instrValid = (occupancy>0). Pop on instrValid & instrReady.
- Latency: registered request; the earliest instruction appears one cycle after memValid.
- Bypass: FIFO empty plus memValid makes the word visible on the next edge, not combinationally.
- Simultaneous push and pop: both happen; occupancy unchanged.
- Redirect cycle:
  - A pop in the same cycle completes (the CPU consumed it).
  - All remaining FIFO entries are flushed.
  - dropCount := outstanding minus responses arriving this cycle. Those arriving responses are discarded too.
  - No request is issued in the redirect cycle.
  - fetchPc := redirectPc; halted clears.
  - The first request to redirectPc goes out the following cycle.
- Redirect while dropCount>0: dropCount accumulates per the same rule (set to current outstanding minus same-cycle arrivals).
- State machine:
  - RUN: normal issuing.
  - DRAIN: dropCount>0. Issuing continues, and new responses queue behind the dropped ones in order.
  - HALT: feature only.
  - Transitions: RUN->DRAIN on redirect with outstanding>0; DRAIN->RUN when dropCount reaches 0.
- Reset mid-operation: every state element clears immediately. Late memValid strobes after reset are treated as protocol errors.

Optional Feature:
- Macro FETCH_HALT_EN.
- With the macro:
  - When a word with opcode 4'hF is pushed into the FIFO, issuing stops and halted=1 on the next cycle.
  - Already-outstanding responses are still accepted, pushed, and presented.
  - Only redirect or reset clears halted and resumes fetch.
- Without the macro:
  - Opcode 4'hF is an ordinary instruction.
  - halted is tied to 0 and the HALT state is absent.

Test Plan:
- Streaming:
  - Stimulus: reset, memory model latency 1 with word = {4'h1, 8'h00, addr[3:0]}, instrReady=1.
  - Required: instrPc sequence 0,1,2,3..., issue starts on the first cycle after reset release.
  - Required: one instruction per cycle after 3-cycle startup.
- Backpressure:
  - Stimulus: instrReady=0 for 10 cycles.
  - Required: exactly DEPTH=4 requests issued; memReq then 0 and instrValid held with PC 0.
  - Required: on release, PCs 0..3 then 4 with no loss or duplication.
- Redirect with in-flight:
  - Stimulus: latency 3, redirect to 0x40 while 3 requests are outstanding.
  - Required: 3 responses dropped; next instrPc=0x40, then 0x41.
- Redirect with same-cycle pop and memValid:
  - Required: the popped instruction is counted as consumed, the arriving word is discarded, and the FIFO is empty next cycle.
- Wrap:
  - Stimulus: redirect to 0xFE.
  - Required: instrPc sequence 0xFE, 0xFF, 0x00.
- Halt (FETCH_HALT_EN defined):
  - Stimulus: word 0xF000 at address 2.
  - Required: halted=1; no memReq for 20 cycles after the last outstanding response; instructions 0..2 are still delivered.
  - Required: redirect to 0x10 clears halted and fetch resumes at 0x10.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with an in-order response FIFO.
// Requests go out while credit (DEPTH - buffered - outstanding) is non-zero.
// A redirect flushes the FIFO and marks every in-flight response for discard.
// Optional build macro FETCH_HALT_EN stops fetch after an opcode 4'hF word
// is buffered. Only a redirect or a reset resumes fetch after that.
module fetch_queue #(
  parameter int PC_WIDTH          = 8,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int DEPTH             = 4
) (
  input  logic                         clock,
  input  logic                         isResetN,
  output logic                         memReq,
  output logic [PC_WIDTH-1:0]          memAddr,
  input  logic [INSTRUCTION_WIDTH-1:0] memData,
  input  logic                         memValid,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]          instrPc,
  output logic                         instrValid,
  input  logic                         instrReady,
  input  logic                         redirect,
  input  logic [PC_WIDTH-1:0]          redirectPc,
  output logic                         halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALT} state_e;
`else
  typedef enum logic [1:0] {S_RUN, S_DRAIN} state_e;
`endif

  state_e                         state_q, state_d;
  logic                           alive_q;
  logic [PC_WIDTH-1:0]            fetchPc_q, fetchPc_d;
  logic [INSTRUCTION_WIDTH-1:0]   fifoWord_q [DEPTH];
  logic [PC_WIDTH-1:0]            fifoPc_q   [DEPTH];
  logic [AW-1:0]                  rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
  logic [CW-1:0]                  count_q, count_d;
  logic [PC_WIDTH-1:0]            tagPc_q    [DEPTH];
  logic [AW-1:0]                  tagRd_q, tagRd_d, tagWr_q, tagWr_d;
  logic [CW-1:0]                  outst_q, outst_d;
  logic [CW-1:0]                  drop_q, drop_d;

  logic [CW:0] used;
  logic        isHalted, pop, resp, push, haltWord;

  assign used = {1'b0, count_q} + {1'b0, outst_q};

`ifdef FETCH_HALT_EN
  assign isHalted = (state_q == S_HALT);
  assign haltWord = (memData[INSTRUCTION_WIDTH-1 -: 4] == 4'hF);
`else
  assign isHalted = 1'b0;
  assign haltWord = 1'b0;
`endif

  // alive_q keeps issue off until the first edge after reset release.
  assign memReq      = alive_q && (used < DEPTH_C) && !redirect && !isHalted;
  assign memAddr     = fetchPc_q;
  assign halted      = isHalted;
  assign instrValid  = (count_q != '0);
  assign instruction = instrValid ? fifoWord_q[rdPtr_q] : '0;
  assign instrPc     = instrValid ? fifoPc_q[rdPtr_q]   : '0;

  assign pop  = instrValid && instrReady;
  // A strobe with nothing outstanding is a protocol error and is ignored.
  assign resp = memValid && (outst_q != '0);
  // Responses still owed to a pre-redirect PC stream are discarded.
  assign push = resp && (drop_q == '0) && !redirect;

  // Next-state for FIFO pointers, in-flight tags, credit and drop counters.
  always_comb begin
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    count_d   = count_q;
    tagRd_d   = tagRd_q;
    tagWr_d   = tagWr_q;
    outst_d   = outst_q + CW'(memReq) - CW'(resp);
    drop_d    = drop_q;
    fetchPc_d = fetchPc_q;
    if (memReq) begin
      tagWr_d   = tagWr_q + AW'(1);
      fetchPc_d = fetchPc_q + PC_WIDTH'(1);
    end
    if (resp) tagRd_d = tagRd_q + AW'(1);
    if (redirect) begin
      // A same-cycle pop has already been consumed; everything else goes.
      rdPtr_d   = '0;
      wrPtr_d   = '0;
      count_d   = '0;
      drop_d    = outst_q - CW'(resp);
      fetchPc_d = redirectPc;
    end else begin
      if (pop)  rdPtr_d = rdPtr_q + AW'(1);
      if (push) wrPtr_d = wrPtr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (resp && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  // Mode FSM: DRAIN while stale responses are owed, HALT after a halt word.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = (drop_d != '0) ? S_DRAIN : S_RUN;
    end else begin
      case (state_q)
        S_RUN:   if (push && haltWord) begin
`ifdef FETCH_HALT_EN
                   state_d = S_HALT;
`endif
                 end
        S_DRAIN: if (drop_d == '0) state_d = S_RUN;
        default: state_d = state_q;
      endcase
    end
  end

  // Control and counter registers.
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      state_q   <= S_RUN;
      alive_q   <= 1'b0;
      fetchPc_q <= '0;
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      count_q   <= '0;
      tagRd_q   <= '0;
      tagWr_q   <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      alive_q   <= 1'b1;
      fetchPc_q <= fetchPc_d;
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      count_q   <= count_d;
      tagRd_q   <= tagRd_d;
      tagWr_q   <= tagWr_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

  // Instruction FIFO storage; each entry carries the PC tagged at issue.
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifoWord_q[i] <= '0;
        fifoPc_q[i]   <= '0;
      end
    end else if (push) begin
      fifoWord_q[wrPtr_q] <= memData;
      fifoPc_q[wrPtr_q]   <= tagPc_q[tagRd_q];
    end
  end

  // In-order tag queue holding the PC of every outstanding request.
  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      for (int i = 0; i < DEPTH; i++) tagPc_q[i] <= '0;
    end else if (memReq) begin
      tagPc_q[tagWr_q] <= fetchPc_q;
    end
  end

`ifndef SYNTHESIS
  // Flag response strobes that have no matching request.
  always_ff @(posedge clock) begin
    if (isResetN && memValid && (outst_q == '0))
      $error("fetch_queue: memValid with no outstanding request");
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue. It uses a latency-L memory model and a
// queue-level reference. The reference holds a buffered-entry queue and an
// in-flight list with per-entry stale flags. Each cycle every meaningful
// output is checked. Literal expectations pin the delivered PC sequences.
module tb_fetch_queue;
  localparam int DEPTH = 4;

  logic        clock, isResetN;
  logic        memReq, memValid, instrValid, instrReady, redirect, halted;
  logic [7:0]  memAddr, instrPc, redirectPc;
  logic [15:0] memData, instruction;

  fetch_queue #(.PC_WIDTH(8), .INSTRUCTION_WIDTH(16), .DEPTH(DEPTH)) dut (
    .clock(clock), .isResetN(isResetN), .memReq(memReq), .memAddr(memAddr),
    .memData(memData), .memValid(memValid), .instruction(instruction),
    .instrPc(instrPc), .instrValid(instrValid), .instrReady(instrReady),
    .redirect(redirect), .redirectPc(redirectPc), .halted(halted));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { logic [7:0] pc; logic [15:0] w; } ent_t;
  typedef struct { logic [7:0] pc; bit stale; } inf_t;
  typedef struct { logic [7:0] a; int due; } mreq_t;

  ent_t       m_fifo[$];
  inf_t       m_inf[$];
  mreq_t      mq[$];
  logic [7:0] log_q[$];
  logic [7:0] m_pc;
  bit         m_halted, m_alive;
  int         cyc, lat, mode, nreq, npass, ntot;
  logic       last_req;
  logic [7:0] last_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [15:0] word(input logic [7:0] a);
    if (mode == 1 && a == 8'h02) return 16'hF000;
    return {4'h1, 8'h00, a[3:0]};
  endfunction

  task automatic do_reset();
    isResetN = 1'b0; memValid = 1'b0; memData = '0;
    redirect = 1'b0; redirectPc = '0; instrReady = 1'b0;
    m_fifo.delete(); m_inf.delete(); mq.delete(); log_q.delete();
    m_pc = '0; m_halted = 0; m_alive = 0; cyc = 0; nreq = 0;
    #1;
    chk("rst_memReq", memReq, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_instrValid", instrValid, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_instrPc", instrPc, 0);
    chk("rst_halted", halted, 0);
    repeat (2) @(negedge clock);
    isResetN = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare against the reference, advance it.
  task automatic step(input bit rdy, input bit rd, input logic [7:0] rpc);
    bit    mv, exp_req;
    inf_t  e;
    mreq_t r;
    instrReady = rdy; redirect = rd; redirectPc = rpc;
    mv = (mq.size() > 0) && (mq[0].due <= cyc);
    memValid = mv;
    memData  = mv ? word(mq[0].a) : '0;
    #1;
    exp_req = m_alive && (DEPTH - m_fifo.size() - m_inf.size() > 0) && !rd && !m_halted;
    chk("memReq", memReq, exp_req);
    if (exp_req) chk("memAddr", memAddr, m_pc);
    chk("instrValid", instrValid, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      chk("instrPc", instrPc, m_fifo[0].pc);
      chk("instruction", instruction, m_fifo[0].w);
    end
    chk("halted", halted, m_halted);
    last_req = memReq; last_addr = memAddr;
    if (instrValid && rdy) log_q.push_back(instrPc);
    if (mv) r = mq.pop_front();
    if (memReq) begin
      mq.push_back('{a: memAddr, due: cyc + lat});
      nreq++;
    end
    // Reference update, from the externally visible rules.
    if (m_fifo.size() > 0 && rdy) void'(m_fifo.pop_front());
    if (mv && m_inf.size() > 0) begin
      e = m_inf.pop_front();
      if (!rd && !e.stale) begin
        m_fifo.push_back('{pc: e.pc, w: memData});
`ifdef FETCH_HALT_EN
        if (memData[15:12] == 4'hF) m_halted = 1;
`endif
      end
    end
    if (rd) begin
      m_fifo.delete();
      foreach (m_inf[i]) m_inf[i].stale = 1;
      m_pc = rpc; m_halted = 0;
    end
    if (exp_req) begin
      m_inf.push_back('{pc: m_pc, stale: 1'b0});
      m_pc++;
    end
    m_alive = 1;
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  initial begin
    int first;
    npass = 0; ntot = 0; mode = 0; lat = 1;
    isResetN = 1'b1; memValid = 0; memData = '0; redirect = 0; redirectPc = '0; instrReady = 0;
    #1;
    do_reset();

    // Streaming at latency 1.
    first = -1;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 8'h00);
      if (first < 0 && log_q.size() > 0) first = i;
    end
    chk("stream_first_cycle", first, 3);
    chk("stream_count", log_q.size(), 9);
    for (int k = 0; k < 6; k++) chk("stream_pc", log_q[k], k);

    // Reset in mid-stream.
    do_reset();

    // Backpressure.
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00);
    chk("bp_requests", nreq, DEPTH);
    chk("bp_hold_valid", instrValid, 1);
    chk("bp_hold_pc", instrPc, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 8'h00);
    chk("bp_len", log_q.size() >= 6, 1);
    for (int k = 0; k < 6; k++) chk("bp_pc", log_q[k], k);

    // Redirect with three requests in flight at latency 3.
    do_reset();
    lat = 3;
    for (int i = 0; i < 4; i++) step(1, 0, 8'h00);
    chk("rd_outstanding", nreq, 3);
    step(1, 1, 8'h40);
    chk("rd_no_stale", log_q.size(), 0);
    for (int i = 0; i < 12; i++) step(1, 0, 8'h00);
    chk("rd_len", log_q.size() >= 2, 1);
    chk("rd_pc0", log_q[0], 8'h40);
    chk("rd_pc1", log_q[1], 8'h41);

    // Redirect together with a pop and an arriving word.
    do_reset();
    lat = 1;
    for (int i = 0; i < 5; i++) step(1, 0, 8'h00);
    step(1, 1, 8'h20);
    chk("rdpop_consumed_len", log_q.size(), 3);
    chk("rdpop_consumed_pc", log_q[2], 2);
    chk("rdpop_empty", instrValid, 0);
    log_q.delete();
    for (int i = 0; i < 8; i++) step(1, 0, 8'h00);
    chk("rdpop_pc0", log_q[0], 8'h20);
    chk("rdpop_pc1", log_q[1], 8'h21);

    // PC wrap.
    do_reset();
    step(1, 0, 8'h00);
    step(1, 0, 8'h00);
    step(1, 1, 8'hFE);
    log_q.delete();
    for (int i = 0; i < 10; i++) step(1, 0, 8'h00);
    chk("wrap_len", log_q.size() >= 3, 1);
    chk("wrap_pc0", log_q[0], 8'hFE);
    chk("wrap_pc1", log_q[1], 8'hFF);
    chk("wrap_pc2", log_q[2], 8'h00);

    // Opcode F word at address 2.
    do_reset();
    mode = 1;
    for (int i = 0; i < 6; i++) step(1, 0, 8'h00);
    nreq = 0;
    for (int i = 0; i < 20; i++) step(1, 0, 8'h00);
    chk("halt_pc0", log_q[0], 0);
    chk("halt_pc1", log_q[1], 1);
    chk("halt_pc2", log_q[2], 2);
`ifdef FETCH_HALT_EN
    chk("halt_flag", halted, 1);
    chk("halt_no_req", nreq, 0);
    chk("halt_delivered", log_q.size(), 4);
    step(1, 1, 8'h10);
    chk("halt_clear", halted, 0);
    step(1, 0, 8'h00);
    chk("halt_resume_req", last_req, 1);
    chk("halt_resume_addr", last_addr, 8'h10);
    for (int i = 0; i < 6; i++) step(1, 0, 8'h00);
`else
    chk("nohalt_flag", halted, 0);
    chk("nohalt_reqs", nreq, 20);
    chk("nohalt_pc3", log_q[3], 3);
    chk("nohalt_pc4", log_q[4], 4);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
